psola_frame_ctrl: RTL
=====================

# psola_frame_ctrl

Frame-level scheduler for the pitch-shift path. It pairs each captured input frame with its pitch period from the pitch detector, then zeroes the PSOLA output accumulator bank, launches `psola`, and waits for it to finish. It then hands the finished output bank to playback. Input and output frames are both ping-ponged, so capture, processing and playback overlap.

## Interface
Parameters:
- `WINDOW_SIZE`, 2048: samples per frame; power of two.
- `TIMEOUT_CYCLES`, 65536: RUN-state watchdog limit.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `frame_full_in`  in  1  pulse: capture finished filling an input bank.
- `frame_bank_in`  in  1  which input bank just filled.
- `tau_valid_in`  in  1  pulse: pitch period available.
- `tau_in`  in  11  pitch period in samples; 0 means unvoiced.
- `psola_tau_valid_out`  out  1  one-cycle launch pulse to `psola`.
- `psola_tau_out`  out  11  period for `psola`; held stable until the next launch.
- `psola_in_bank_out`  out  1  input bank `psola` reads.
- `psola_out_bank_out`  out  1  output bank `psola` accumulates into.
- `psola_len_valid_in`  in  1  `psola` done pulse.
- `psola_len_in`  in  12  output length from `psola`.
- `clr_we_out`  out  1  zero-write enable into the output accumulator.
- `clr_addr_out`  out  12  zero-write address.
- `play_busy_in`  in  1  playback still reading its bank.
- `play_start_out`  out  1  one-cycle pulse: start playback.
- `play_len_out`  out  12  samples to play.
- `play_bank_out`  out  1  bank to play.
- `play_raw_out`  out  1  1 = play the raw input bank; 0 = play the processed output bank.
- `busy_out`  out  1  state ≠ IDLE.
- `overrun_out`  out  1  sticky: a frame was dropped.
- `timeout_out`  out  1  sticky: the watchdog fired.

Reset values: every output is 0, `out_bank` is 0, both pending flags are 0, and the state is IDLE.

## Operation
- Pending latches:
  - `frame_full_in` sets `frame_pend` and stores the bank.
  - `tau_valid_in` sets `tau_pend` and stores tau; a newer tau overwrites the stored one silently.
  - `frame_full_in` while `frame_pend` = 1: the newer bank replaces the stored one and `overrun_out` is set.
  - An event arriving in the cycle its pending flag is consumed sets the flag again (set wins over clear).
- States:
  - IDLE: when `frame_pend` and `tau_pend` are both 1, latch the bank and tau and clear both flags.
    - tau = 0: go to HANDOFF with raw = 1 and len = `WINDOW_SIZE`.
    - Otherwise: go to CLEAR.
  - CLEAR: `clr_we_out` = 1; `clr_addr_out` counts 0 to `WINDOW_SIZE`−1, one address per cycle, into bank `out_bank`; then go to LAUNCH.
  - LAUNCH: pulse `psola_tau_valid_out` for one cycle with tau and both bank selects valid; zero the watchdog; go to RUN.
  - RUN:
    - `psola_len_valid_in`: latch `psola_len_in`, set raw = 0, go to HANDOFF.
    - Watchdog reaches `TIMEOUT_CYCLES`−1: set `timeout_out` and go to IDLE; the frame is dropped and nothing is played.
  - HANDOFF: wait while `play_busy_in` = 1.
    - Then pulse `play_start_out` with `play_len_out`, `play_raw_out`, and `play_bank_out` (= `out_bank` if processed, else the input bank).
    - Toggle `out_bank` only for processed frames.
    - Go to IDLE.
- `psola_len_valid_in` outside RUN is ignored.
- `play_len_out`, `play_bank_out` and `play_raw_out` hold until the next `play_start_out`.
- The sticky flags clear only on reset.
- Reset mid-operation returns to IDLE immediately; no partial pulses. `psola` shares the same reset.

## Timing
- Both pending flags seen in IDLE at cycle t:
  - CLEAR addresses appear at t+1 through t+`WINDOW_SIZE`.
  - `psola_tau_valid_out` fires at t+`WINDOW_SIZE`+1.
- Unvoiced frame: `play_start_out` fires at t+1 if `play_busy_in` = 0.
- `psola_len_valid_in` at cycle r: `play_start_out` fires at r+1 if playback is idle, otherwise the cycle after `play_busy_in` falls.
- Watchdog counts RUN cycles only; the first RUN cycle counts as 0.
- Throughput: one frame per (`WINDOW_SIZE` + `psola` runtime + 3) cycles at minimum.

## Structure
- `psola_pkg` holds:
  - the `state_t` enum {IDLE, CLEAR, LAUNCH, RUN, HANDOFF};
  - `TAU_W` = 11 and `LEN_W` = 12;
  - the `WINDOW_SIZE` default.
- One sub-module, `watchdog_timer` (parameter `LIMIT`; ports: clear, enable, expired).
- Everything else is inline.

## Test plan
- `WINDOW_SIZE` = 16, frame bank 0, tau = 5:
  - 16 clear writes at addresses 0–15;
  - launch pulse with tau 5, in bank 0, out bank 0;
  - return len 22 → `play_start_out`, len 22, bank 0, raw 0; `out_bank` becomes 1.
- tau = 0 with frame bank 1 → no clear and no launch; the next cycle `play_start_out`, len 16, bank 1, raw 1; `out_bank` unchanged.
- Tau arrives 40 cycles before the frame, and a second tau = 7 overwrites it → launch uses 7; `overrun_out` stays 0.
- Two `frame_full_in` pulses (banks 0 then 1) during RUN → `overrun_out` = 1, and the next frame uses bank 1.
- `TIMEOUT_CYCLES` = 32, `psola` never answers → `timeout_out` set in RUN cycle 31, back to IDLE, no `play_start_out`.
- `play_busy_in` held high for 10 cycles in HANDOFF → `play_start_out` fires exactly once, the cycle after it drops. Separately, reset asserted during CLEAR → all outputs 0 asynchronously, and the state is IDLE after release.

Source files
------------

// File: rtl/psola_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psola_pkg
//  Purpose  : Shared types and widths for the PSOLA frame controller slice.
//             Holds the scheduler state encoding, the tau/length widths, the
//             default frame size and the playback descriptor struct.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package psola_pkg;

    localparam int TAU_W                  = 11;
    localparam int LEN_W                  = 12;
    localparam int DEFAULT_WINDOW_SIZE    = 2048;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LAUNCH  = 3'd2,
        RUN     = 3'd3,
        HANDOFF = 3'd4
    } state_t;

    // What playback is told to do for one frame.
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             bank;
        logic             raw;
    } play_desc_t;

endpackage : psola_pkg
`default_nettype wire

// File: rtl/psola_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : psola_frame_ctrl_if
//  Purpose  : Bundles every frame-controller signal except clock and reset:
//             capture events, pitch period, psola launch/done handshake,
//             accumulator clear port, playback handshake and status flags.
//  Ports    : modport master - the frame controller
//             modport slave  - capture / pitch / psola / playback side
//  Revision : 1.0 - initial release
// ============================================================================
interface psola_frame_ctrl_if;
    import psola_pkg::*;

    logic             frame_full_in;
    logic             frame_bank_in;
    logic             tau_valid_in;
    logic [TAU_W-1:0] tau_in;
    logic             psola_tau_valid_out;
    logic [TAU_W-1:0] psola_tau_out;
    logic             psola_in_bank_out;
    logic             psola_out_bank_out;
    logic             psola_len_valid_in;
    logic [LEN_W-1:0] psola_len_in;
    logic             clr_we_out;
    logic [LEN_W-1:0] clr_addr_out;
    logic             play_busy_in;
    logic             play_start_out;
    logic [LEN_W-1:0] play_len_out;
    logic             play_bank_out;
    logic             play_raw_out;
    logic             busy_out;
    logic             overrun_out;
    logic             timeout_out;

    modport master (
        input  frame_full_in, frame_bank_in, tau_valid_in, tau_in,
               psola_len_valid_in, psola_len_in, play_busy_in,
        output psola_tau_valid_out, psola_tau_out, psola_in_bank_out,
               psola_out_bank_out, clr_we_out, clr_addr_out,
               play_start_out, play_len_out, play_bank_out, play_raw_out,
               busy_out, overrun_out, timeout_out
    );

    modport slave (
        output frame_full_in, frame_bank_in, tau_valid_in, tau_in,
               psola_len_valid_in, psola_len_in, play_busy_in,
        input  psola_tau_valid_out, psola_tau_out, psola_in_bank_out,
               psola_out_bank_out, clr_we_out, clr_addr_out,
               play_start_out, play_len_out, play_bank_out, play_raw_out,
               busy_out, overrun_out, timeout_out
    );

endinterface : psola_frame_ctrl_if
`default_nettype wire

// File: rtl/watchdog_timer.sv
`default_nettype none
// ============================================================================
//  Module   : watchdog_timer
//  Purpose  : Counts enabled cycles since the last clear and flags the cycle
//             in which the count reaches LIMIT-1. The first enabled cycle
//             after a clear counts as 0.
//  Ports    : clk_in  - clock
//             rst_in  - asynchronous active-high reset
//             clear   - zero the count
//             enable  - count this cycle
//             expired - enabled cycle whose count is LIMIT-1
//  Revision : 1.0 - initial release
// ============================================================================
module watchdog_timer #(
    parameter int LIMIT = 65536
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int             CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule : watchdog_timer
`default_nettype wire

// File: rtl/psola_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psola_frame_ctrl
//  Purpose  : Frame scheduler for the pitch-shift path. Pairs each captured
//             input frame with its pitch period, zeroes the output
//             accumulator bank, launches psola, waits for completion (with a
//             watchdog) and hands the result to playback. Unvoiced frames
//             (tau = 0) bypass processing and play the raw input bank.
//  Ports    : clk_in, rst_in - clock, asynchronous active-high reset
//             bus (master)   - capture/pitch inputs, psola launch/done,
//                              accumulator clear port, playback handshake,
//                              busy / overrun / timeout status
//  Revision : 1.0 - initial release
// ============================================================================
module psola_frame_ctrl
    import psola_pkg::*;
#(
    parameter int WINDOW_SIZE    = DEFAULT_WINDOW_SIZE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    psola_frame_ctrl_if.master bus
);

    localparam logic [LEN_W-1:0] C_WIN_LAST = LEN_W'(WINDOW_SIZE - 1);
    localparam logic [LEN_W-1:0] C_WIN_LEN  = LEN_W'(WINDOW_SIZE);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_frame_pend;
    logic             r_frame_bank;
    logic             r_tau_pend;
    logic [TAU_W-1:0] r_tau_val;

    logic             r_cur_bank;     // input bank of the frame in flight
    logic [TAU_W-1:0] r_cur_tau;
    logic             r_out_bank;     // output bank the next processed frame uses
    logic [LEN_W-1:0] r_len;
    logic             r_raw;
    logic [LEN_W-1:0] r_clr_addr;

    logic [TAU_W-1:0] r_psola_tau;
    logic             r_psola_in_bank;
    logic             r_psola_out_bank;

    play_desc_t       r_play_held;
    logic             r_overrun;
    logic             r_timeout;

    // ------------------------------------------------------------------------
    // FSM decode strobes
    // ------------------------------------------------------------------------
    logic             w_consume;
    logic             w_clr_we;
    logic             w_clr_last;
    logic             w_launch;
    logic             w_wd_clear;
    logic             w_wd_enable;
    logic             w_wd_expired;
    logic             w_run_done;
    logic             w_run_timeout;
    logic             w_play_start;
    play_desc_t       w_play_desc;

    assign w_clr_last = (r_clr_addr == C_WIN_LAST);

    watchdog_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_consume     = 1'b0;
        w_clr_we      = 1'b0;
        w_launch      = 1'b0;
        w_wd_clear    = 1'b0;
        w_wd_enable   = 1'b0;
        w_run_done    = 1'b0;
        w_run_timeout = 1'b0;
        w_play_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_frame_pend && r_tau_pend) begin
                    w_consume   = 1'b1;
                    w_state_nxt = (r_tau_val == '0) ? HANDOFF : CLEAR;
                end
            end
            CLEAR: begin
                w_clr_we = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_launch    = 1'b1;
                w_wd_clear  = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_wd_enable = 1'b1;
                // A done pulse in the expiry cycle still counts as success.
                if (bus.psola_len_valid_in) begin
                    w_run_done  = 1'b1;
                    w_state_nxt = HANDOFF;
                end else if (w_wd_expired) begin
                    w_run_timeout = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            HANDOFF: begin
                if (!bus.play_busy_in) begin
                    w_play_start = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending latches. A new event in the consume cycle wins over the clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame_pend <= 1'b0;
            r_frame_bank <= 1'b0;
            r_tau_pend   <= 1'b0;
            r_tau_val    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (bus.frame_full_in) begin
                r_frame_pend <= 1'b1;
                r_frame_bank <= bus.frame_bank_in;
            end else if (w_consume) begin
                r_frame_pend <= 1'b0;
            end
            // Only a frame that is still waiting gets dropped; one taken in
            // this very cycle is not an overrun.
            if (bus.frame_full_in && r_frame_pend && !w_consume) begin
                r_overrun <= 1'b1;
            end
            if (bus.tau_valid_in) begin
                r_tau_pend <= 1'b1;
                r_tau_val  <= bus.tau_in;
            end else if (w_consume) begin
                r_tau_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------------
    assign w_play_desc = '{len:  r_len,
                           bank: r_raw ? r_cur_bank : r_out_bank,
                           raw:  r_raw};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cur_bank       <= 1'b0;
            r_cur_tau        <= '0;
            r_out_bank       <= 1'b0;
            r_len            <= '0;
            r_raw            <= 1'b0;
            r_clr_addr       <= '0;
            r_psola_tau      <= '0;
            r_psola_in_bank  <= 1'b0;
            r_psola_out_bank <= 1'b0;
            r_play_held      <= '0;
            r_timeout        <= 1'b0;
        end else begin
            if (w_consume) begin
                r_cur_bank <= r_frame_bank;
                r_cur_tau  <= r_tau_val;
                if (r_tau_val == '0) begin
                    r_len <= C_WIN_LEN;
                    r_raw <= 1'b1;
                end
            end
            if (w_clr_we) begin
                r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
            end
            // Load the psola operands on the way into LAUNCH so they are
            // valid during the pulse and hold until the next launch.
            if (w_clr_we && w_clr_last) begin
                r_psola_tau      <= r_cur_tau;
                r_psola_in_bank  <= r_cur_bank;
                r_psola_out_bank <= r_out_bank;
            end
            if (w_run_done) begin
                r_len <= bus.psola_len_in;
                r_raw <= 1'b0;
            end
            if (w_run_timeout) begin
                r_timeout <= 1'b1;
            end
            if (w_play_start) begin
                r_play_held <= w_play_desc;
                if (!r_raw) begin
                    r_out_bank <= ~r_out_bank;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Playback fields show the new descriptor only in the start
    // cycle, otherwise the last one handed over.
    // ------------------------------------------------------------------------
    assign bus.psola_tau_valid_out = w_launch;
    assign bus.psola_tau_out       = r_psola_tau;
    assign bus.psola_in_bank_out   = r_psola_in_bank;
    assign bus.psola_out_bank_out  = r_psola_out_bank;
    assign bus.clr_we_out          = w_clr_we;
    assign bus.clr_addr_out        = r_clr_addr;
    assign bus.play_start_out      = w_play_start;
    assign bus.play_len_out        = w_play_start ? w_play_desc.len  : r_play_held.len;
    assign bus.play_bank_out       = w_play_start ? w_play_desc.bank : r_play_held.bank;
    assign bus.play_raw_out        = w_play_start ? w_play_desc.raw  : r_play_held.raw;
    assign bus.busy_out            = (r_state != IDLE);
    assign bus.overrun_out         = r_overrun;
    assign bus.timeout_out         = r_timeout;

endmodule : psola_frame_ctrl
`default_nettype wire
